// File: rtl/bpu_upd_queue.sv
// Branch-resolution update queue between the BJP execution unit and the BTAC/PHT write port.
// Optional same-cycle empty-queue bypass under `define BPU_UPD_BYPASS_EN.

module bpu_upd_kill #(
  parameter int W = 8
) (
  input  logic         i_trap,
  input  logic         i_ls,
  input  logic [W-1:0] i_ls_id,
  input  logic         i_mis,
  input  logic [W-1:0] i_mis_id,
  input  logic [W-1:0] i_rob_id,
  output logic         o_kill
);
  // a is older than b; the MSB is the ROB wrap bit
  function automatic logic older(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a[W-1] != b[W-1]) older = (a[W-2:0] >= b[W-2:0]);
    else                  older = (a[W-2:0] <  b[W-2:0]);
  endfunction

  assign o_kill = i_trap
                | (i_ls  & (older(i_ls_id, i_rob_id) | (i_ls_id == i_rob_id)))
                | (i_mis & older(i_mis_id, i_rob_id));
endmodule

module bpu_upd_queue #(
  parameter int DEPTH        = 4,
  parameter int PC_WIDTH     = 32,
  parameter int ROB_ID_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_exu_iq_btac_vld,
  input  logic [ROB_ID_WIDTH-1:0] i_exu_iq_rob_id,
  input  logic                    i_exu_iq_btac_taken,
  input  logic                    i_exu_iq_btac_new_br,
  input  logic                    i_exu_iq_type,
  input  logic                    i_exu_iq_len,
  input  logic                    i_exu_iq_tsucc,
  input  logic [PC_WIDTH-1:0]     i_exu_iq_btac_addr,
  input  logic [PC_WIDTH-1:0]     i_exu_iq_btac_taddr,
  input  logic [1:0]              i_exu_iq_btac_idx,
  input  logic [11:0]             i_exu_iq_pht_idx,
  input  logic [1:0]              i_exu_iq_pht_status,
  input  logic                    i_csr_trap_flush,
  input  logic                    i_exu_ls_flush,
  input  logic [ROB_ID_WIDTH-1:0] i_exu_ls_rob_id,
  input  logic                    i_exu_mis_flush,
  input  logic [ROB_ID_WIDTH-1:0] i_exu_mis_rob_id,
  input  logic                    i_bpu_upd_rdy,
  output logic                    o_bpu_upd_vld,
  output logic                    o_bpu_upd_taken,
  output logic                    o_bpu_upd_new_br,
  output logic                    o_bpu_upd_type,
  output logic                    o_bpu_upd_len,
  output logic                    o_bpu_upd_tsucc,
  output logic [PC_WIDTH-1:0]     o_bpu_upd_addr,
  output logic [PC_WIDTH-1:0]     o_bpu_upd_taddr,
  output logic [1:0]              o_bpu_upd_btac_idx,
  output logic [11:0]             o_bpu_upd_pht_idx,
  output logic [1:0]              o_bpu_upd_pht_status,
  output logic                    o_upd_full,
  output logic [$clog2(DEPTH):0]  o_upd_cnt,
  output logic                    o_upd_drop
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic                taken;
    logic                new_br;
    logic                typ;
    logic                len;
    logic                tsucc;
    logic [PC_WIDTH-1:0] addr;
    logic [PC_WIDTH-1:0] taddr;
    logic [1:0]          btac_idx;
    logic [11:0]         pht_idx;
    logic [1:0]          pht_status;
  } upd_t;

  logic [AW:0]             head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]        live_q, live_d, kill_slot;
  upd_t                    slot_q [DEPTH];
  upd_t                    slot_d [DEPTH];
  logic [ROB_ID_WIDTH-1:0] rob_q  [DEPTH];
  logic [ROB_ID_WIDTH-1:0] rob_d  [DEPTH];
  logic [AW-1:0]           hidx, tidx;
  logic                    kill_in, empty, full, byp, vld, pop, adv, push;
  upd_t                    in_pkt, hd;

  assign hidx = head_q[AW-1:0];
  assign tidx = tail_q[AW-1:0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_kill
    bpu_upd_kill #(.W(ROB_ID_WIDTH)) u_kill (
      .i_trap(i_csr_trap_flush), .i_ls(i_exu_ls_flush), .i_ls_id(i_exu_ls_rob_id),
      .i_mis(i_exu_mis_flush), .i_mis_id(i_exu_mis_rob_id),
      .i_rob_id(rob_q[i]), .o_kill(kill_slot[i])
    );
  end

  bpu_upd_kill #(.W(ROB_ID_WIDTH)) u_kill_in (
    .i_trap(i_csr_trap_flush), .i_ls(i_exu_ls_flush), .i_ls_id(i_exu_ls_rob_id),
    .i_mis(i_exu_mis_flush), .i_mis_id(i_exu_mis_rob_id),
    .i_rob_id(i_exu_iq_rob_id), .o_kill(kill_in)
  );

  always_comb begin
    in_pkt = '{taken: i_exu_iq_btac_taken, new_br: i_exu_iq_btac_new_br,
               typ: i_exu_iq_type, len: i_exu_iq_len, tsucc: i_exu_iq_tsucc,
               addr: i_exu_iq_btac_addr, taddr: i_exu_iq_btac_taddr,
               btac_idx: i_exu_iq_btac_idx, pht_idx: i_exu_iq_pht_idx,
               pht_status: i_exu_iq_pht_status};
    empty = (head_q == tail_q);
    full  = (head_q[AW-1:0] == tail_q[AW-1:0]) & (head_q[AW] != tail_q[AW]);
`ifdef BPU_UPD_BYPASS_EN
    byp = empty & i_exu_iq_btac_vld & ~kill_in;
`else
    byp = 1'b0;
`endif
    vld  = byp | (~empty & live_q[hidx] & ~kill_slot[hidx]);
    pop  = vld & i_bpu_upd_rdy;
    // a dead, unretired head slot is skipped one per cycle without a handshake
    adv  = (pop & ~byp) | (~empty & ~live_q[hidx]);
    push = i_exu_iq_btac_vld & ~full & ~kill_in & ~(byp & i_bpu_upd_rdy);
    hd   = byp ? in_pkt : slot_q[hidx];

    head_d = head_q + {{AW{1'b0}}, adv};
    tail_d = tail_q + {{AW{1'b0}}, push};
    live_d = live_q & ~kill_slot;
    slot_d = slot_q;
    rob_d  = rob_q;
    if (adv) live_d[hidx] = 1'b0;
    if (push) begin
      live_d[tidx] = 1'b1;
      slot_d[tidx] = in_pkt;
      rob_d[tidx]  = i_exu_iq_rob_id;
    end
    if (i_csr_trap_flush) begin
      head_d = '0;
      tail_d = '0;
      live_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      live_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
        rob_q[i]  <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      live_q <= live_d;
      slot_q <= slot_d;
      rob_q  <= rob_d;
    end
  end

  assign o_bpu_upd_vld      = vld;
  assign o_bpu_upd_taken    = hd.taken;
  assign o_bpu_upd_new_br   = hd.new_br;
  assign o_bpu_upd_type     = hd.typ;
  assign o_bpu_upd_len      = hd.len;
  assign o_bpu_upd_tsucc    = hd.tsucc;
  assign o_bpu_upd_addr     = hd.addr;
  assign o_bpu_upd_taddr    = hd.taddr;
  assign o_bpu_upd_btac_idx = hd.btac_idx;
  assign o_bpu_upd_pht_idx  = hd.pht_idx;
  assign o_upd_full         = full;
  assign o_upd_cnt          = tail_q - head_q;
  assign o_upd_drop         = i_exu_iq_btac_vld & full;

  always_comb begin
    if (hd.new_br)     o_bpu_upd_pht_status = hd.taken ? 2'b10 : 2'b01;
    else if (hd.taken) o_bpu_upd_pht_status = (hd.pht_status == 2'b11) ? 2'b11 : hd.pht_status + 2'b01;
    else               o_bpu_upd_pht_status = (hd.pht_status == 2'b00) ? 2'b00 : hd.pht_status - 2'b01;
  end
endmodule

// File: doc/bpu_upd_queue.md
# bpu_upd_queue

Buffers branch-resolution updates from the BJP execution unit and drains them, one per handshake, to the BTAC/PHT update port of the branch prediction unit. Computes the next 2-bit PHT counter value for each entry. Discards wrong-path updates on trap, load/store and mispredict flushes. Sits between the BJP `o_exu_iq_*` outputs and the IFU predictor write port. The predictor may stall via `i_bpu_upd_rdy` without back-pressuring execution.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; a power of two, at least 2.
- `PC_WIDTH`, 32: PC width.
- `ROB_ID_WIDTH`, 8: ROB id width; the MSB is the wrap bit.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset. Asynchronous assertion, active-low. One clock domain.
- `i_exu_iq_btac_vld` in 1: update push.
- `i_exu_iq_rob_id` in ROB_ID_WIDTH: ROB id of the resolving branch.
- `i_exu_iq_btac_taken`, `i_exu_iq_btac_new_br`, `i_exu_iq_type`, `i_exu_iq_len`, `i_exu_iq_tsucc` in 1 each: resolution flags.
- `i_exu_iq_btac_addr`, `i_exu_iq_btac_taddr` in PC_WIDTH: branch PC and resolved target.
- `i_exu_iq_btac_idx` in 2: BTAC way.
- `i_exu_iq_pht_idx` in 12: PHT index.
- `i_exu_iq_pht_status` in 2: predicted counter value.
- `i_csr_trap_flush` in 1: kill all entries.
- `i_exu_ls_flush` in 1, with `i_exu_ls_rob_id` in ROB_ID_WIDTH: kill entries younger than or equal to `i_exu_ls_rob_id`.
- `i_exu_mis_flush` in 1, with `i_exu_mis_rob_id` in ROB_ID_WIDTH: kill entries strictly younger than `i_exu_mis_rob_id`.
- `i_bpu_upd_rdy` in 1: predictor accepts the head entry.
- `o_bpu_upd_vld` out 1: head entry valid.
- `o_bpu_upd_taken`, `o_bpu_upd_new_br`, `o_bpu_upd_type`, `o_bpu_upd_len`, `o_bpu_upd_tsucc` out 1 each: head entry flags.
- `o_bpu_upd_addr`, `o_bpu_upd_taddr` out PC_WIDTH: head entry PC and target.
- `o_bpu_upd_btac_idx` out 2: head entry BTAC way.
- `o_bpu_upd_pht_idx` out 12: head entry PHT index.
- `o_bpu_upd_pht_status` out 2: next PHT counter value.
- `o_upd_full` out 1: queue full.
- `o_upd_cnt` out log2(DEPTH)+1: occupied slots.
- `o_upd_drop` out 1: one-cycle pulse when a push is lost to a full queue.

## Operation
- Circular buffer with head pointer, tail pointer and a per-slot live bit. Pointers are log2(DEPTH)+1 bits; the extra bit is the wrap bit.
- Pointer states:
  - empty: `head == tail`.
  - full: indices equal and wrap bits differ.
- Push: `i_exu_iq_btac_vld & ~full` at the start of the cycle writes the slot at tail and advances tail.
  - A same-cycle pop does not free space for the push.
  - A push to a full queue is discarded and `o_upd_drop` pulses for one cycle.
- Age comparison: a is older than b if
  - wrap bits differ: `a[W-2:0] >= b[W-2:0]`;
  - wrap bits equal: `a[W-2:0] < b[W-2:0]`.
- Kill rules, evaluated per slot and on the incoming push in the same cycle:
  - `i_csr_trap_flush`: every slot is killed and pointers reset to empty.
  - ls flush: kills an entry if `i_exu_ls_rob_id` is older than it, or equal to it.
  - mis flush: kills an entry only if `i_exu_mis_rob_id` is older than it; the mispredicting branch itself survives.
  - A killed incoming push is not written and does not advance tail.
- Drain: `o_bpu_upd_vld = ~empty & live[head] & ~kill_head_now`.
  - Head advances on `o_bpu_upd_vld & i_bpu_upd_rdy`.
  - Head also advances, without a handshake, when the head slot is not empty but not live: one dead slot retired per cycle.
- PHT next value, `o_bpu_upd_pht_status`:
  - new_br=1: `taken ? 2'b10 : 2'b01`.
  - otherwise: saturating counter; taken increments to a maximum of 3, not-taken decrements to a minimum of 0.
- `o_upd_cnt = tail - head`. It includes dead slots not yet retired.

## Timing
- Reset values:
  - pointers 0; all live bits 0.
  - `o_bpu_upd_vld` 0, `o_upd_full` 0, `o_upd_cnt` 0, `o_upd_drop` 0.
  - payload outputs 0, because slot storage is reset.
- Reset asserted mid-operation empties the queue immediately, without waiting for a clock edge.
- Latency: a pushed entry appears at the output in the cycle after the push.
- Kill masking on `o_bpu_upd_vld` is combinational in the flush cycle. The live-bit clear takes effect at the next edge.
- Back-to-back pops: one entry per cycle while `i_bpu_upd_rdy` stays high.
- Output payload is held stable while `o_bpu_upd_vld & ~i_bpu_upd_rdy`.

## Configuration
- `BPU_UPD_BYPASS_EN` defined:
  - When the queue is empty, a non-killed push is presented on the outputs in the same cycle.
  - If `i_bpu_upd_rdy=1` in that cycle, the push is consumed with no write.
  - If `i_bpu_upd_rdy=0`, the push is written normally.
- `BPU_UPD_BYPASS_EN` undefined: minimum latency is 1 cycle, as in Timing.

## Test plan
- Push 4 updates with rdy=0, then a fifth push:
  - `o_upd_full`=1 and `o_upd_drop` pulses on the fifth push.
  - Raising rdy then drains the 4 entries in push order over 4 cycles.
- Pht_status=3, taken=1 gives 3; status=0, taken=0 gives 0; status=1, taken=1 gives 2; new_br=1, taken=0 gives 1.
- Entries with ROB ids 0x05, 0x06, 0x07, then mis flush with id 0x05: only 0x05 is delivered; `o_upd_cnt` reaches 0 within 3 cycles.
- Wrap-around age: entries 0x7E and 0x81, then ls flush with id 0x7F: 0x7E survives and 0x81 is killed.
- Trap flush with the head valid and rdy=1: `o_bpu_upd_vld`=0 that cycle, and the next cycle the queue is empty.
- With `BPU_UPD_BYPASS_EN`, empty queue, push with rdy=1: `o_bpu_upd_vld`=1 in the same cycle and `o_upd_cnt` stays 0.
